// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt/reset entry sequencer.
//   - state encoding (localparam codes of type state_t)
//   - sequence kind enum (reset / nmi / brk / irq)
//   - default vector addresses, stack page, BRK opcode
package interrupt_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StDummy   = 3'd1;
  localparam state_t StPushPch = 3'd2;
  localparam state_t StPushPcl = 3'd3;
  localparam state_t StPushP   = 3'd4;
  localparam state_t StVecLo   = 3'd5;
  localparam state_t StVecHi   = 3'd6;
  // Held while rst is low; leaves into a RESET sequence on the first edge after release.
  localparam state_t StRstPend = 3'd7;

  typedef enum logic [1:0] {
    KindReset = 2'd0,
    KindNmi   = 2'd1,
    KindBrk   = 2'd2,
    KindIrq   = 2'd3
  } kind_e;

  localparam logic [15:0] VEC_NMI    = 16'hFFFA;
  localparam logic [15:0] VEC_RST    = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ    = 16'hFFFE;
  localparam logic [7:0]  STACK_PAGE = 8'h01;
  localparam logic [7:0]  OP_BRK     = 8'h00;

endpackage

// File: rtl/status_push_fmt.sv
// Formats the status byte pushed during an interrupt/reset sequence.
//   p           - live status register
//   brk         - 1 when the sequence is a BRK (sets the B bit)
//   status_byte - p with bit5 forced to 1 and bit4 = brk
module status_push_fmt (
  input  logic [7:0] p,
  input  logic       brk,
  output logic [7:0] status_byte
);

  assign status_byte = {p[7:6], 1'b1, brk, p[3:0]};

endmodule

// File: rtl/interrupt_sequencer.sv
// Six-cycle interrupt / BRK / reset entry sequencer.
// Inputs : clk_ph1, rst (async, active low), nmi_pend, irq_pend, brk_op, fetch_cycle,
//          pc, p, sp, din
// Outputs: addr, dout, rw (1 = read), sp_dec, pc_load, pc_val, i_set, nmi_clr, irq_clr, busy
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter logic [15:0] VecNmi = VEC_NMI,
  parameter logic [15:0] VecRst = VEC_RST,
  parameter logic [15:0] VecIrq = VEC_IRQ
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic        nmi_pend,
  input  logic        irq_pend,
  input  logic        brk_op,
  input  logic        fetch_cycle,
  input  logic [15:0] pc,
  input  logic [7:0]  p,
  input  logic [7:0]  sp,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        rw,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_val,
  output logic        i_set,
  output logic        nmi_clr,
  output logic        irq_clr,
  output logic        busy
);

  state_t      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [7:0]  vec_lo_q, vec_lo_d;
  logic [7:0]  status_byte;
  logic [15:0] vector;
  logic        start;

  assign start = fetch_cycle & (nmi_pend | brk_op | irq_pend);

  status_push_fmt u_status_push_fmt (
    .p           (p),
    .brk         (kind_q == KindBrk),
    .status_byte (status_byte)
  );

  // Kind is rewritten to NMI on a hijack, so the vector and clear pulses follow it.
  always_comb begin
    unique case (kind_q)
      KindNmi:   vector = VecNmi;
      KindReset: vector = VecRst;
      default:   vector = VecIrq;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    vec_lo_d = vec_lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDummy;
          if (nmi_pend)    kind_d = KindNmi;
          else if (brk_op) kind_d = KindBrk;
          else             kind_d = KindIrq;
        end
      end
      StRstPend: begin
        state_d = StDummy;
        kind_d  = KindReset;
      end
      StDummy:   state_d = StPushPch;
      StPushPch: state_d = StPushPcl;
      StPushPcl: state_d = StPushP;
      StPushP: begin
        state_d = StVecLo;
        // NMI hijack: decided once, on entry to VEC_LO.
        if ((kind_q == KindBrk || kind_q == KindIrq) && nmi_pend) kind_d = KindNmi;
      end
      StVecLo: begin
        state_d  = StVecHi;
        vec_lo_d = din;
      end
      StVecHi:   state_d = StIdle;
      default:   state_d = StRstPend;
    endcase
  end

  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      state_q  <= StRstPend;
      kind_q   <= KindReset;
      vec_lo_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      vec_lo_q <= vec_lo_d;
    end
  end

  always_comb begin
    addr    = pc;
    dout    = 8'h00;
    rw      = 1'b1;
    sp_dec  = 1'b0;
    pc_load = 1'b0;
    pc_val  = {din, vec_lo_q};
    i_set   = 1'b0;
    nmi_clr = 1'b0;
    irq_clr = 1'b0;
    busy    = 1'b1;
    unique case (state_q)
      StIdle:    busy = 1'b0;
      StRstPend: addr = 16'h0000;
      StDummy:   ;
      StPushPch, StPushPcl, StPushP: begin
        addr   = {STACK_PAGE, sp};
        sp_dec = 1'b1;
        // Reset walks the stack pointer but suppresses the writes.
        rw     = (kind_q == KindReset);
        if (state_q == StPushPch)      dout = pc[15:8];
        else if (state_q == StPushPcl) dout = pc[7:0];
        else                           dout = status_byte;
      end
      StVecLo: begin
        addr  = vector;
        i_set = 1'b1;
      end
      StVecHi: begin
        addr    = vector + 16'd1;
        pc_load = 1'b1;
        nmi_clr = (kind_q == KindNmi);
        irq_clr = (kind_q == KindIrq);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

  logic        clk_ph1 = 1'b0;
  logic        rst;
  logic        nmi_pend = 1'b0, irq_pend = 1'b0, brk_op = 1'b0, fetch_cycle = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic [7:0]  p = 8'h00, sp = 8'hFD, din;
  logic [15:0] addr, pc_val;
  logic [7:0]  dout;
  logic        rw, sp_dec, pc_load, i_set, nmi_clr, irq_clr, busy;
  logic [29:0] obs;

  int checks = 0;
  int errors = 0;

  interrupt_sequencer dut (
    .clk_ph1     (clk_ph1),
    .rst         (rst),
    .nmi_pend    (nmi_pend),
    .irq_pend    (irq_pend),
    .brk_op      (brk_op),
    .fetch_cycle (fetch_cycle),
    .pc          (pc),
    .p           (p),
    .sp          (sp),
    .din         (din),
    .addr        (addr),
    .dout        (dout),
    .rw          (rw),
    .sp_dec      (sp_dec),
    .pc_load     (pc_load),
    .pc_val      (pc_val),
    .i_set       (i_set),
    .nmi_clr     (nmi_clr),
    .irq_clr     (irq_clr),
    .busy        (busy)
  );

  always #5 clk_ph1 = ~clk_ph1;

  // Memory model: vector table; everything else reads as NOP.
  always_comb begin
    case (addr)
      16'hFFFA: din = 8'h00;
      16'hFFFB: din = 8'hA0;
      16'hFFFC: din = 8'h00;
      16'hFFFD: din = 8'h80;
      16'hFFFE: din = 8'h00;
      16'hFFFF: din = 8'h90;
      default:  din = 8'hEA;
    endcase
  end

  // Observed bundle: addr, rw, dout, sp_dec, i_set, pc_load, nmi_clr, irq_clr
  assign obs = {addr, rw, dout, sp_dec, i_set, pc_load, nmi_clr, irq_clr};

  task automatic test_reset();
    logic [29:0] exp [6];
    logic [29:0] idle_exp;
    pc = 16'h1234; sp = 8'hFD; p = 8'h00;
    @(negedge clk_ph1);
    checks++;
    if (obs !== {16'h0000, 1'b1, 8'h00, 5'b00000} || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold obs=%h busy=%b exp=%h busy=1", obs, busy,
               {16'h0000, 1'b1, 8'h00, 5'b00000});
    end
    rst = 1'b1;
    exp[0] = {16'h1234, 1'b1, 8'h00, 5'b00000};
    exp[1] = {16'h01FD, 1'b1, 8'h12, 5'b10000};
    exp[2] = {16'h01FD, 1'b1, 8'h34, 5'b10000};
    exp[3] = {16'h01FD, 1'b1, 8'h20, 5'b10000};
    exp[4] = {16'hFFFC, 1'b1, 8'h00, 5'b01000};
    exp[5] = {16'hFFFD, 1'b1, 8'h00, 5'b00100};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_ph1);
      checks++;
      if (obs !== exp[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL reset_seq[%0d] obs=%h busy=%b exp=%h busy=1", i, obs, busy, exp[i]);
      end
      if (i == 5) begin
        checks++;
        if (pc_val !== 16'h8000) begin
          errors++;
          $display("FAIL reset_pc_val got=%h exp=8000", pc_val);
        end
      end
    end
    @(negedge clk_ph1);
    idle_exp = {pc, 1'b1, 8'h00, 5'b00000};
    checks++;
    if (obs !== idle_exp || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle obs=%h busy=%b exp=%h busy=0", obs, busy, idle_exp);
    end
  endtask

  task automatic test_irq();
    logic [29:0] exp [6];
    pc = 16'hC123; sp = 8'hFD; p = 8'h00;
    irq_pend = 1'b1; fetch_cycle = 1'b1;
    exp[0] = {16'hC123, 1'b1, 8'h00, 5'b00000};
    exp[1] = {16'h01FD, 1'b0, 8'hC1, 5'b10000};
    exp[2] = {16'h01FD, 1'b0, 8'h23, 5'b10000};
    exp[3] = {16'h01FD, 1'b0, 8'h20, 5'b10000};
    exp[4] = {16'hFFFE, 1'b1, 8'h00, 5'b01000};
    exp[5] = {16'hFFFF, 1'b1, 8'h00, 5'b00101};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_ph1);
      checks++;
      if (obs !== exp[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL irq_seq[%0d] obs=%h busy=%b exp=%h busy=1", i, obs, busy, exp[i]);
      end
      if (i == 5) begin
        checks++;
        if (pc_val !== 16'h9000) begin
          errors++;
          $display("FAIL irq_pc_val got=%h exp=9000", pc_val);
        end
        irq_pend = 1'b0; fetch_cycle = 1'b0;
      end
    end
    @(negedge clk_ph1);
    checks++;
    if (busy !== 1'b0 || obs !== {16'hC123, 1'b1, 8'h00, 5'b00000}) begin
      errors++;
      $display("FAIL irq_idle obs=%h busy=%b exp=%h busy=0", obs, busy,
               {16'hC123, 1'b1, 8'h00, 5'b00000});
    end
  endtask

  task automatic test_brk();
    logic [29:0] exp [6];
    pc = 16'h4000; sp = 8'hFA; p = 8'h01;
    brk_op = 1'b1; fetch_cycle = 1'b1;
    exp[0] = {16'h4000, 1'b1, 8'h00, 5'b00000};
    exp[1] = {16'h01FA, 1'b0, 8'h40, 5'b10000};
    exp[2] = {16'h01FA, 1'b0, 8'h00, 5'b10000};
    exp[3] = {16'h01FA, 1'b0, 8'h31, 5'b10000};
    exp[4] = {16'hFFFE, 1'b1, 8'h00, 5'b01000};
    exp[5] = {16'hFFFF, 1'b1, 8'h00, 5'b00100};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_ph1);
      checks++;
      if (obs !== exp[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL brk_seq[%0d] obs=%h busy=%b exp=%h busy=1", i, obs, busy, exp[i]);
      end
      if (i == 0) begin
        brk_op = 1'b0; fetch_cycle = 1'b0;
      end
      if (i == 5) begin
        checks++;
        if (pc_val !== 16'h9000) begin
          errors++;
          $display("FAIL brk_pc_val got=%h exp=9000", pc_val);
        end
      end
    end
    @(negedge clk_ph1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL brk_idle busy=%b exp=0", busy);
    end
  endtask

  task automatic test_nmi_hijack();
    logic [29:0] exp [6];
    pc = 16'h2222; sp = 8'hF0; p = 8'h00;
    irq_pend = 1'b1; fetch_cycle = 1'b1;
    exp[0] = {16'h2222, 1'b1, 8'h00, 5'b00000};
    exp[1] = {16'h01F0, 1'b0, 8'h22, 5'b10000};
    exp[2] = {16'h01F0, 1'b0, 8'h22, 5'b10000};
    exp[3] = {16'h01F0, 1'b0, 8'h20, 5'b10000};
    exp[4] = {16'hFFFA, 1'b1, 8'h00, 5'b01000};
    exp[5] = {16'hFFFB, 1'b1, 8'h00, 5'b00110};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_ph1);
      checks++;
      if (obs !== exp[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL hijack_seq[%0d] obs=%h busy=%b exp=%h busy=1", i, obs, busy, exp[i]);
      end
      if (i == 0) fetch_cycle = 1'b0;
      if (i == 2) nmi_pend = 1'b1;
      if (i == 5) begin
        checks++;
        if (pc_val !== 16'hA000) begin
          errors++;
          $display("FAIL hijack_pc_val got=%h exp=A000", pc_val);
        end
        nmi_pend = 1'b0; irq_pend = 1'b0;
      end
    end
    @(negedge clk_ph1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hijack_idle busy=%b exp=0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] exp_n [6];
    logic [29:0] exp_i [6];
    pc = 16'h3000; sp = 8'hFF; p = 8'h00;
    nmi_pend = 1'b1; irq_pend = 1'b1; fetch_cycle = 1'b1;
    exp_n[0] = {16'h3000, 1'b1, 8'h00, 5'b00000};
    exp_n[1] = {16'h01FF, 1'b0, 8'h30, 5'b10000};
    exp_n[2] = {16'h01FF, 1'b0, 8'h00, 5'b10000};
    exp_n[3] = {16'h01FF, 1'b0, 8'h20, 5'b10000};
    exp_n[4] = {16'hFFFA, 1'b1, 8'h00, 5'b01000};
    exp_n[5] = {16'hFFFB, 1'b1, 8'h00, 5'b00110};
    exp_i[0] = exp_n[0];
    exp_i[1] = exp_n[1];
    exp_i[2] = exp_n[2];
    exp_i[3] = exp_n[3];
    exp_i[4] = {16'hFFFE, 1'b1, 8'h00, 5'b01000};
    exp_i[5] = {16'hFFFF, 1'b1, 8'h00, 5'b00101};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_ph1);
      checks++;
      if (obs !== exp_n[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_nmi[%0d] obs=%h busy=%b exp=%h busy=1", i, obs, busy, exp_n[i]);
      end
      if (i == 5) nmi_pend = 1'b0;
    end
    // fetch_cycle and irq_pend stay high: must idle one cycle before starting again.
    @(negedge clk_ph1);
    checks++;
    if (busy !== 1'b0 || obs !== {16'h3000, 1'b1, 8'h00, 5'b00000}) begin
      errors++;
      $display("FAIL b2b_gap obs=%h busy=%b exp=%h busy=0", obs, busy,
               {16'h3000, 1'b1, 8'h00, 5'b00000});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_ph1);
      checks++;
      if (obs !== exp_i[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_irq[%0d] obs=%h busy=%b exp=%h busy=1", i, obs, busy, exp_i[i]);
      end
      if (i == 5) begin
        irq_pend = 1'b0; fetch_cycle = 1'b0;
      end
    end
    @(negedge clk_ph1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%b exp=0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [29:0] exp [6];
    logic [29:0] rst_exp;
    pc = 16'h5000; sp = 8'hFD; p = 8'h00;
    irq_pend = 1'b1; fetch_cycle = 1'b1;
    rst_exp = {16'h0000, 1'b1, 8'h00, 5'b00000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_ph1);
      if (i == 0) fetch_cycle = 1'b0;
      if (i == 3) begin
        checks++;
        if (obs !== {16'h01FD, 1'b0, 8'h20, 5'b10000}) begin
          errors++;
          $display("FAIL mid_push_p obs=%h exp=%h", obs, {16'h01FD, 1'b0, 8'h20, 5'b10000});
        end
        rst = 1'b0;
        irq_pend = 1'b0;
        #1;
        checks++;
        if (obs !== rst_exp || busy !== 1'b1) begin
          errors++;
          $display("FAIL mid_abort obs=%h busy=%b exp=%h busy=1", obs, busy, rst_exp);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_ph1);
      checks++;
      if (obs !== rst_exp || busy !== 1'b1) begin
        errors++;
        $display("FAIL mid_hold[%0d] obs=%h busy=%b exp=%h busy=1", i, obs, busy, rst_exp);
      end
    end
    rst = 1'b1;
    exp[0] = {16'h5000, 1'b1, 8'h00, 5'b00000};
    exp[1] = {16'h01FD, 1'b1, 8'h50, 5'b10000};
    exp[2] = {16'h01FD, 1'b1, 8'h00, 5'b10000};
    exp[3] = {16'h01FD, 1'b1, 8'h20, 5'b10000};
    exp[4] = {16'hFFFC, 1'b1, 8'h00, 5'b01000};
    exp[5] = {16'hFFFD, 1'b1, 8'h00, 5'b00100};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_ph1);
      checks++;
      if (obs !== exp[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset_seq[%0d] obs=%h busy=%b exp=%h busy=1", i, obs, busy, exp[i]);
      end
      if (i == 5) begin
        checks++;
        if (pc_val !== 16'h8000) begin
          errors++;
          $display("FAIL mid_reset_pc_val got=%h exp=8000", pc_val);
        end
      end
    end
    @(negedge clk_ph1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle busy=%b exp=0", busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached, simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    test_reset();
    test_irq();
    test_brk();
    test_nmi_hijack();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
